// File: rtl/pkt_filter_dispatch.sv
// Packet filter and dispatcher: decodes type/destination, drops disallowed or duplicate
// packets, pulses one processing-unit enable and holds busy until done or timeout.
module pkt_filter_dispatch #(
    parameter int                    WORD_WIDTH     = 16,
    parameter int                    SEQ_WIDTH      = 8,
    parameter int                    DUP_DEPTH      = 4,
    parameter int                    TIMEOUT        = 255,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID       = '1,
    parameter int                    DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      newpkt,
    input  logic [2:0]                fPktType,
    input  logic [WORD_WIDTH-1:0]     myNodeID,
    input  logic [WORD_WIDTH-1:0]     destinationID,
    input  logic [WORD_WIDTH-1:0]     sourceID,
    input  logic [SEQ_WIDTH-1:0]      pktSeq,
    input  logic [7:0]                type_en,
    input  logic                      unit_done,
    output logic                      en_QTU,
    output logic                      en_MNI,
    output logic                      en_KCH,
    output logic                      en_reward,
    output logic                      iAmDestination,
    output logic                      busy,
    output logic                      pkt_dropped,
    output logic                      timeout,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int PTR_W = (DUP_DEPTH > 1) ? $clog2(DUP_DEPTH) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] T_HB   = 3'd0;
    localparam logic [2:0] T_CHE  = 3'd1;
    localparam logic [2:0] T_INV  = 3'd2;
    localparam logic [2:0] T_MR   = 3'd3;
    localparam logic [2:0] T_CHT  = 3'd4;
    localparam logic [2:0] T_DATA = 3'd5;

    // Route vector bit order: {QTU, MNI, KCH, reward}
    localparam logic [3:0] R_QTU = 4'b1000;
    localparam logic [3:0] R_MNI = 4'b0100;
    localparam logic [3:0] R_KCH = 4'b0010;
    localparam logic [3:0] R_REW = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            wait_cnt_q, wait_cnt_d;
    logic [3:0]                  en_q, en_d;
    logic                        iam_q, iam_d;
    logic                        dropped_q;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                        timeout_hit;

    logic [WORD_WIDTH-1:0]       cache_src_q [DUP_DEPTH];
    logic [SEQ_WIDTH-1:0]        cache_seq_q [DUP_DEPTH];
    logic [DUP_DEPTH-1:0]        cache_vld_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [DUP_DEPTH-1:0]        hit_vec;

    logic                        addr_match;
    logic                        addr_bcast;
    logic [3:0]                  route;
    logic                        accept;
    logic                        drop;
    logic                        cache_wr;

    assign addr_match = (destinationID == myNodeID);
    assign addr_bcast = (destinationID == BCAST_ID);

    generate
        for (genvar gi = 0; gi < DUP_DEPTH; gi++) begin : g_dup_cmp
            assign hit_vec[gi] = cache_vld_q[gi]
                               && (cache_src_q[gi] == sourceID)
                               && (cache_seq_q[gi] == pktSeq);
        end
    endgenerate

    // An empty route means the packet has nowhere to go and is dropped.
    always_comb begin
        route = '0;
        case (fPktType)
            T_HB:    route = R_MNI | R_REW;
            T_CHE:   route = R_KCH;
            T_INV:   route = R_MNI;
            T_MR:    route = addr_match ? R_MNI : 4'b0000;
            T_CHT:   route = (addr_match || addr_bcast) ? R_MNI : 4'b0000;
            T_DATA:  route = (|hit_vec) ? 4'b0000 : (R_QTU | R_REW);
            default: route = '0;
        endcase
    end

    assign accept   = newpkt && (state_q == ST_IDLE) && type_en[fPktType] && (route != 4'b0000);
    assign drop     = newpkt && !accept;
    assign cache_wr = accept && (fPktType == T_DATA);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        en_d        = '0;
        iam_d       = iam_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DISPATCH;
                    en_d    = route;
                    iam_d   = addr_match && !addr_bcast;
                end
            end
            ST_DISPATCH: begin
                if (unit_done) begin
                    state_d = ST_IDLE;
                    iam_d   = 1'b0;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (unit_done) begin
                    state_d = ST_IDLE;
                    iam_d   = 1'b0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = ST_IDLE;
                    iam_d       = 1'b0;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                iam_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            en_q       <= '0;
            iam_q      <= 1'b0;
            dropped_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            en_q       <= en_d;
            iam_q      <= iam_d;
            dropped_q  <= drop;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Only the valid bits and pointer need reset; stale keys are masked by valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cache_vld_q <= '0;
            wr_ptr_q    <= '0;
        end else if (cache_wr) begin
            cache_vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (cache_wr) begin
            cache_src_q[wr_ptr_q] <= sourceID;
            cache_seq_q[wr_ptr_q] <= pktSeq;
        end
    end

    assign en_QTU         = en_q[3];
    assign en_MNI         = en_q[2];
    assign en_KCH         = en_q[1];
    assign en_reward      = en_q[0];
    assign iAmDestination = iam_q;
    assign busy           = (state_q != ST_IDLE);
    assign pkt_dropped    = dropped_q;
    assign timeout        = timeout_hit;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_pkt_filter_dispatch.sv
// Directed plus randomized bench for pkt_filter_dispatch, checked against a rule-table
// model with a FIFO-style duplicate cache and a saturating drop count.
module tb_pkt_filter_dispatch;

    localparam int TIMEOUT   = 255;
    localparam int DUP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        newpkt = 1'b0;
    logic [2:0]  fPktType = '0;
    logic [15:0] my_id = 16'h000C;
    logic [15:0] destinationID = '0;
    logic [15:0] sourceID = '0;
    logic [7:0]  pktSeq = '0;
    logic [7:0]  type_en = 8'hFF;
    logic        unit_done = 1'b0;
    logic        en_QTU, en_MNI, en_KCH, en_reward;
    logic        iAmDestination, busy, pkt_dropped, timeout;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    pkt_filter_dispatch #(
        .WORD_WIDTH    (16),
        .SEQ_WIDTH     (8),
        .DUP_DEPTH     (DUP_DEPTH),
        .TIMEOUT       (TIMEOUT),
        .BCAST_ID      (16'hFFFF),
        .DROP_CNT_WIDTH(8)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .newpkt        (newpkt),
        .fPktType      (fPktType),
        .myNodeID      (my_id),
        .destinationID (destinationID),
        .sourceID      (sourceID),
        .pktSeq        (pktSeq),
        .type_en       (type_en),
        .unit_done     (unit_done),
        .en_QTU        (en_QTU),
        .en_MNI        (en_MNI),
        .en_KCH        (en_KCH),
        .en_reward     (en_reward),
        .iAmDestination(iAmDestination),
        .busy          (busy),
        .pkt_dropped   (pkt_dropped),
        .timeout       (timeout),
        .drop_cnt      (drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: remembered DATA keys (oldest first) and drop count.
    logic [23:0] cache_m[$];
    int          m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Rule table: which units a packet reaches, ignoring timing entirely.
    function automatic void model_pkt(input logic [2:0] t, input logic [15:0] dest,
                                      input logic [15:0] src, input logic [7:0] seq,
                                      input bit is_busy, output bit acc,
                                      output logic [3:0] en, output bit iam);
        bit match;
        bit bc;
        bit dup;
        match = (dest == my_id);
        bc    = (dest == 16'hFFFF);
        dup   = 1'b0;
        foreach (cache_m[k]) if (cache_m[k] == {src, seq}) dup = 1'b1;
        en = 4'b0000;
        case (t)
            3'd0: en = 4'b0101;
            3'd1: en = 4'b0010;
            3'd2: en = 4'b0100;
            3'd3: en = match ? 4'b0100 : 4'b0000;
            3'd4: en = (match || bc) ? 4'b0100 : 4'b0000;
            3'd5: en = dup ? 4'b0000 : 4'b1001;
            default: en = 4'b0000;
        endcase
        acc = !is_busy && type_en[t] && (en != 4'b0000);
        if (!acc) en = 4'b0000;
        if (acc && t == 3'd5) begin
            cache_m.push_back({src, seq});
            if (cache_m.size() > DUP_DEPTH) void'(cache_m.pop_front());
        end
        if (!acc && m_drops < 255) m_drops++;
        iam = acc && match && !bc;
    endfunction

    // done_after: busy cycle in which unit_done is raised (0 = never).
    // intr_at: busy cycle in which a second packet is offered (0 = never).
    task automatic step(input logic [2:0] t, input logic [15:0] dest, input logic [15:0] src,
                        input logic [7:0] seq, input int done_after, input int intr_at,
                        input string tag);
        bit         acc, iam, inj_prev, xacc, xiam;
        logic [3:0] en, xen;
        int         c;
        @(negedge clk);
        newpkt = 1'b1; fPktType = t; destinationID = dest; sourceID = src; pktSeq = seq;
        model_pkt(t, dest, src, seq, 1'b0, acc, en, iam);
        @(posedge clk); #1;
        newpkt = 1'b0;
        if (!acc) begin
            chk({tag, "/dropped"}, pkt_dropped, 1);
            chk({tag, "/en"}, {en_QTU, en_MNI, en_KCH, en_reward}, 0);
            chk({tag, "/busy"}, busy, 0);
            chk({tag, "/drop_cnt"}, drop_cnt, m_drops);
            $display("[%0t] %s type=%0d dest=%h src=%h seq=%h -> dropped, drop_cnt=%0d",
                     $time, tag, t, dest, src, seq, drop_cnt);
            return;
        end
        inj_prev = 1'b0;
        for (c = 1; c <= TIMEOUT + 1; c++) begin
            chk({tag, "/busy"}, busy, 1);
            chk({tag, "/iam"}, iAmDestination, iam);
            chk({tag, "/en"}, {en_QTU, en_MNI, en_KCH, en_reward}, (c == 1) ? en : 4'b0000);
            chk({tag, "/dropped"}, pkt_dropped, inj_prev);
            chk({tag, "/drop_cnt"}, drop_cnt, m_drops);
            @(negedge clk);
            unit_done = (c == done_after);
            inj_prev  = (c == intr_at);
            if (inj_prev) begin
                newpkt = 1'b1; fPktType = 3'd1; destinationID = my_id;
                model_pkt(3'd1, my_id, 16'h0, 8'h0, 1'b1, xacc, xen, xiam);
            end
            #1;
            chk({tag, "/timeout"}, timeout, (c == TIMEOUT + 1) && (c != done_after));
            @(posedge clk); #1;
            unit_done = 1'b0;
            newpkt    = 1'b0;
            if (c == done_after || c == TIMEOUT + 1) break;
        end
        chk({tag, "/busy_end"}, busy, 0);
        chk({tag, "/iam_end"}, iAmDestination, 0);
        chk({tag, "/en_end"}, {en_QTU, en_MNI, en_KCH, en_reward}, 0);
        chk({tag, "/timeout_end"}, timeout, 0);
        chk({tag, "/dropped_end"}, pkt_dropped, inj_prev);
        chk({tag, "/drop_cnt_end"}, drop_cnt, m_drops);
        $display("[%0t] %s type=%0d dest=%h src=%h seq=%h -> units=%b iam=%0d busy_cycles=%0d drop_cnt=%0d",
                 $time, tag, t, dest, src, seq, en, iam, c, drop_cnt);
    endtask

    initial begin
        logic [2:0]  rt;
        logic [15:0] rd;
        int          rdone, rintr;

        #1;
        chk("reset/busy", busy, 0);
        chk("reset/en", {en_QTU, en_MNI, en_KCH, en_reward}, 0);
        chk("reset/iam", iAmDestination, 0);
        chk("reset/dropped", pkt_dropped, 0);
        chk("reset/timeout", timeout, 0);
        chk("reset/drop_cnt", drop_cnt, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        step(3'd0, 16'h0000, 16'h0001, 8'h00, 3, 0, "hb_basic");
        step(3'd1, 16'h0008, 16'h0001, 8'h00, 2, 0, "che_other");
        step(3'd1, 16'h000C, 16'h0001, 8'h00, 4, 0, "che_mine");
        step(3'd3, 16'h000D, 16'h0001, 8'h00, 1, 0, "mr_miss");
        step(3'd3, 16'h000C, 16'h0001, 8'h00, 1, 0, "mr_hit");
        step(3'd4, 16'hFFFF, 16'h0001, 8'h00, 2, 0, "cht_bcast");
        step(3'd4, 16'h0007, 16'h0001, 8'h00, 2, 0, "cht_miss");
        step(3'd2, 16'h0005, 16'h0001, 8'h00, 2, 0, "inv");

        step(3'd5, 16'h000C, 16'h0003, 8'h10, 1, 0, "data_first");
        step(3'd5, 16'h000C, 16'h0003, 8'h10, 1, 0, "data_dup");
        for (int i = 0; i < 5; i++) step(3'd5, 16'h000C, 16'h0004, 8'(i), 2, 0, "data_fill");
        step(3'd5, 16'h000C, 16'h0003, 8'h10, 2, 0, "data_evicted");

        type_en = 8'hFD;
        step(3'd1, 16'h000C, 16'h0001, 8'h00, 2, 0, "che_masked");
        type_en = 8'hFF;
        step(3'd7, 16'h000C, 16'h0001, 8'h00, 2, 0, "reserved7");
        step(3'd6, 16'h000C, 16'h0001, 8'h00, 2, 0, "reserved6");

        step(3'd0, 16'h000C, 16'h0001, 8'h00, 0, 5, "hb_timeout");
        step(3'd0, 16'h000C, 16'h0001, 8'h00, TIMEOUT + 1, 0, "hb_done_at_expiry");
        step(3'd0, 16'h0000, 16'h0001, 8'h00, 1, 1, "hb_back_to_back");

        for (int i = 0; i < 60; i++) begin
            type_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            rt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       rd = my_id;
                1:       rd = 16'hFFFF;
                default: rd = 16'($urandom_range(0, 15));
            endcase
            rdone = $urandom_range(1, 6);
            rintr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rdone) : 0;
            step(rt, rd, 16'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), rdone, rintr, "rand");
        end
        type_en = 8'hFF;

        for (int i = 0; i < 300; i++) step(3'd7, 16'h000C, 16'h0001, 8'h00, 1, 0, "saturate");
        chk("saturate/final", drop_cnt, 8'hFF);

        step(3'd5, 16'h0001, 16'hAAAA, 8'h55, 1, 0, "data_pre_reset");
        @(negedge clk);
        newpkt = 1'b1; fPktType = 3'd0; destinationID = 16'h0000;
        @(posedge clk); #1;
        newpkt = 1'b0;
        chk("rst_wait/busy_before", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait/busy_mid", busy, 1);
        nrst = 1'b0;
        #1;
        chk("rst_wait/busy", busy, 0);
        chk("rst_wait/en", {en_QTU, en_MNI, en_KCH, en_reward}, 0);
        chk("rst_wait/iam", iAmDestination, 0);
        chk("rst_wait/dropped", pkt_dropped, 0);
        chk("rst_wait/timeout", timeout, 0);
        chk("rst_wait/drop_cnt", drop_cnt, 0);
        $display("[%0t] reset asserted mid-WAIT", $time);
        cache_m.delete();
        m_drops = 0;
        @(negedge clk);
        nrst = 1'b1;
        step(3'd5, 16'h0001, 16'hAAAA, 8'h55, 2, 0, "data_after_reset");
        step(3'd5, 16'h0001, 16'hAAAA, 8'h55, 2, 0, "data_dup_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_filter_dispatch.md
# pkt_filter_dispatch

Parametrised successor to the node's packet filter. Decodes each received packet's type and destination, applies a per-type enable mask, suppresses duplicate DATA packets through a small source/sequence cache, and dispatches a one-cycle enable to the QTU, MNI, KCH or reward unit. It then holds `busy` until the selected unit reports completion or a timeout expires. It sits between the packet receiver and the EER-RL processing units.

## Interface
- `WORD_WIDTH`, 16, width of node IDs.
- `SEQ_WIDTH`, 8, width of packet sequence number.
- `DUP_DEPTH`, 4, entries in duplicate cache (power of two, ≥2).
- `TIMEOUT`, 255, max WAIT cycles before forced return to IDLE (≥1).
- `BCAST_ID`, all-ones, destination ID treated as broadcast.
- `DROP_CNT_WIDTH`, 8, width of saturating drop counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `nrst`  in  1  asynchronous active-low reset.
- `newpkt`  in  1  one-cycle strobe, packet fields valid.
- `fPktType`  in  3  0 HB, 1 CHE, 2 INV, 3 MR, 4 CHT, 5 DATA, 6–7 reserved.
- `myNodeID`  in  WORD_WIDTH  this node's ID.
- `destinationID`  in  WORD_WIDTH  packet destination.
- `sourceID`  in  WORD_WIDTH  packet source.
- `pktSeq`  in  SEQ_WIDTH  packet sequence number.
- `type_en`  in  8  per-type accept mask, bit n = type n.
- `unit_done`  in  1  completion pulse from the dispatched unit.
- `en_QTU`, `en_MNI`, `en_KCH`, `en_reward`  out  1 each  one-cycle dispatch enables.
- `iAmDestination`  out  1  dispatched packet is addressed to `myNodeID` (not broadcast).
- `busy`  out  1  high in DISPATCH and WAIT.
- `pkt_dropped`  out  1  one-cycle pulse per dropped packet.
- `timeout`  out  1  one-cycle pulse when WAIT expires.
- `drop_cnt`  out  DROP_CNT_WIDTH  saturating count of drops.

## Operation
- States: IDLE, DISPATCH, WAIT.
- A packet is accepted only in IDLE.
- Match is `destinationID == myNodeID`. Broadcast is `destinationID == BCAST_ID`.
- Dispatch map:
  - HB → MNI+reward.
  - CHE → KCH.
  - INV → MNI.
  - MR → MNI, match only.
  - CHT → MNI, match or broadcast.
  - DATA → QTU+reward.
- Drop conditions:
  - the type bit in `type_en` is clear;
  - reserved type;
  - MR/CHT address miss;
  - DATA whose {sourceID, pktSeq} hits a valid cache entry;
  - `newpkt` while `busy`.
- Duplicate cache:
  - Accepted DATA writes {sourceID, pktSeq, valid} at a round-robin pointer, then the pointer increments modulo DUP_DEPTH.
  - Only DATA is looked up or written.
  - Cache is cleared at reset only.
- Transitions:
  - IDLE + accepted `newpkt` → DISPATCH. IDLE + dropped `newpkt` stays in IDLE.
  - DISPATCH → IDLE if `unit_done` is high in that cycle, else → WAIT.
  - WAIT → IDLE on `unit_done` or when the counter reaches TIMEOUT. `timeout` pulses in the expiry cycle unless `unit_done` is also high (`unit_done` wins).
- `iAmDestination` is latched at acceptance, held while `busy`, and cleared on return to IDLE.
- `drop_cnt` increments once per drop and saturates at all-ones.

## Timing
- Reset: state IDLE; all outputs 0; `drop_cnt` 0; cache invalid; pointer 0.
- Reset asserted mid-DISPATCH/WAIT aborts immediately, with no `timeout` pulse.
- Dispatch latency: `newpkt` sampled at edge N; enables and `busy` high in cycle N+1 for exactly one cycle. `busy` stays high until the edge at which WAIT exits.
- `pkt_dropped` is registered, high in cycle N+1.
- WAIT counter starts at 1 on entry. With no `unit_done`, `busy` covers 1 + TIMEOUT cycles.
- Earliest next accept: the cycle in which state is IDLE again.
- Back-to-back `newpkt` in consecutive cycles: the first is accepted, the second is dropped.
- A duplicate check against an entry written in the same cycle cannot happen, because an accept forces `busy`.

## Test plan
- Reset, `myNodeID`=0x000C, `type_en`=0xFF; HB with dest 0x0000 → `en_MNI`=`en_reward`=1 for one cycle at N+1, `iAmDestination`=0, `unit_done` at N+3 → `busy` low at N+4.
- CHE dest 0x0008 → `en_KCH` pulse, `iAmDestination`=0. CHE dest 0x000C → `en_KCH` pulse, `iAmDestination`=1 while busy. MR dest 0x000D → `pkt_dropped` pulse, `drop_cnt`=1, no enables.
- DATA src 0x0003 seq 0x10 twice (with `unit_done` between) → first gives `en_QTU`+`en_reward`, second gives `pkt_dropped`. Five further distinct DATA packets, then src 0x0003 seq 0x10 again → accepted, because the entry was evicted with DUP_DEPTH=4.
- `type_en`=0xFD, CHE → dropped. Type 7 with `type_en`=0xFF → dropped.
- HB dispatched, no `unit_done` → `busy` high 256 cycles, `timeout` pulse in the last, then IDLE. `newpkt` during WAIT → dropped and counted.
- 300 drops → `drop_cnt` holds 255. Assert `nrst` mid-WAIT → all outputs 0 at once, cache cleared.
